alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Sequences the shared 32-bit ALU (ops: 000 add, 001 sub, 010 and, 011 or, 100 xor) for the multicycle core.
//  Decodes RV32I funct3/funct7[5] into ALU ops, synthesises SLT/SLTU from SUB plus sign logic, and
//  implements SLL/SRL/SRA iteratively. Sits between the main control FSM (req/resp) and the ALU instance.
// PARAMETERS
//  XLEN   32  datapath width; only 32 is supported
//  SHW    5   shift-amount width, log2(XLEN)
// PORTS
//  clk        in   1     rising-edge clock; the only clock
//  rst        in   1     synchronous, active-high reset
//  req_valid  in   1     operation request
//  req_ready  out  1     high only in IDLE; accept = req_valid & req_ready
//  funct3     in   3     RV32I funct3 (000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and)
//  funct7_5   in   1     selects sub (funct3=000) or sra (funct3=101); ignored otherwise
//  opa        in   32    rs1 operand, captured on accept
//  opb        in   32    rs2/imm operand, captured on accept; shamt = opb[4:0]
//  alu_op     out  3     to ALU Op
//  alu_a      out  32    to ALU a
//  alu_b      out  32    to ALU b
//  alu_out    in   32    from ALU out
//  alu_sign   in   1     from ALU SignBit (alu_out[31])
//  resp_valid out  1     one-cycle pulse; result valid in that cycle; no backpressure
//  result     out  32    registered result; held until next resp_valid
//  busy       out  1     high when state != IDLE
// BEHAVIOUR
//  States: IDLE, EXEC, SHIFT, DONE. Operands, funct3 and funct7_5 are latched on accept.
//  IDLE -accept, single-pass op-> EXEC; IDLE -accept, shift op-> SHIFT (cnt <= shamt, acc <= opa).
//  EXEC: 1 cycle; drive alu_op/alu_a=opa/alu_b=opb; result <= decoded value; -> DONE.
//  SHIFT: SLL drives alu_op=000, alu_a=alu_b=acc, acc <= alu_out; SRL/SRA acc <= {fill, acc[31:1]},
//    fill = opa[31] for SRA else 0, ALU inputs zero. cnt decrements each cycle; when cnt<=1 -> DONE and
//    result <= final acc. shamt=0: one SHIFT cycle, result = opa unchanged.
//  DONE: resp_valid=1 for exactly one cycle; -> IDLE. req_ready=0 in DONE; no back-to-back accept.
//  Latency accept->resp_valid: single-pass 2 cycles; iterative shift max(shamt,1)+1 cycles.
//  SLT: alu_op=001; result = {31'b0, (opa[31]^opb[31]) ? opa[31] : alu_sign}.
//  SLTU: alu_op=001; result = {31'b0, (opa[31]^opb[31]) ? opb[31] : alu_sign}.
//  ADD/SUB wrap modulo 2^32; no overflow flag. funct7_5 ignored for and/or/xor/slt/sltu/sll/srl.
//  Outside EXEC and SLL-SHIFT cycles: alu_op=000, alu_a=alu_b=0.
//  req_valid while busy: ignored, not queued. opa/opb changes after accept: no effect.
//  Reset (any state, incl. mid-shift): next cycle IDLE, in-flight op dropped, no resp_valid.
//  Reset values: req_ready=1, busy=0, resp_valid=0, result=0, alu_op=000, alu_a=0, alu_b=0, cnt=0, acc=0.
// CONFIGURATION
//  ALU_SEQ_FAST_SHIFT_EN defined: shifts computed by an internal barrel shifter in EXEC; every op has
//    2-cycle latency; SHIFT state unreachable; ALU inputs zero during shifts.
//  Undefined: iterative shifting as above; no barrel shifter synthesised.
// TESTING
//  add: opa=5, opb=7, f3=000, f7_5=0 -> resp_valid 2 cycles after accept, result=12; sub -> 0xFFFFFFFE.
//  slt/sltu: opa=0xFFFFFFFF, opb=1 -> slt result=1, sltu result=0; opa=0x80000000, opb=0x7FFFFFFF -> slt=1.
//  sll: opa=1, opb=31 -> result=0x80000000, resp_valid 32 cycles after accept; opb=0 -> result=1 after 2.
//  sra/srl: opa=0x80000000, shamt=4 -> sra 0xF8000000, srl 0x08000000, latency 5 cycles.
//  busy/reset: req_valid held during sll shamt=10; rst at cycle 5 -> IDLE next cycle, no resp_valid,
//    req_ready=1; held request then accepted and completes normally.
//  ALU_SEQ_FAST_SHIFT_EN build: sll opa=3, shamt=30 -> result=0xC0000000 after 2 cycles.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side signal bundle for alu_sequencer.
// slave: the sequencer; master: the control FSM; alu: the shared ALU instance.
interface alu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            resp_valid;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic            alu_sign;

  modport slave (
    input  req_valid, funct3, funct7_5, opa, opb, alu_out, alu_sign,
    output req_ready, resp_valid, result, busy, alu_op, alu_a, alu_b
  );

  modport master (
    output req_valid, funct3, funct7_5, opa, opb,
    input  req_ready, resp_valid, result, busy
  );

  modport alu (
    input  alu_op, alu_a, alu_b,
    output alu_out, alu_sign
  );
endinterface

// File: rtl/alu_sequencer.sv
// RV32I ALU sequencer: decodes funct3/funct7[5], builds SLT/SLTU from SUB, shifts iteratively.
// Define ALU_SEQ_FAST_SHIFT_EN to compute shifts with a barrel shifter in a single EXEC cycle.
module alu_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic            f7_q;
  logic [XLEN-1:0] opa_q, opb_q;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] exec_res;
  logic            accept;
  logic            req_is_shift;
  logic            iter_shift;
  logic            last_shift;
  logic            fill;

`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FastShift = 1'b1;
  logic [XLEN-1:0] sll_res, srl_res, sra_res;
  assign sll_res = opa_q << opb_q[SHW-1:0];
  assign srl_res = opa_q >> opb_q[SHW-1:0];
  assign sra_res = $signed(opa_q) >>> opb_q[SHW-1:0];
`else
  localparam bit FastShift = 1'b0;
`endif

  assign accept       = bus.req_valid && (state_q == IDLE);
  assign req_is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
  assign iter_shift   = req_is_shift && !FastShift;
  assign last_shift   = (cnt_q <= SHW'(1));
  assign fill         = f7_q & opa_q[XLEN-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = iter_shift ? SHIFT : EXEC;
      EXEC:    state_d = DONE;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ALU drive and single-pass result decode
  always_comb begin
    bus.alu_op = OP_ADD;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    exec_res   = '0;
    if (state_q == EXEC) begin
      case (f3_q)
        3'b000: begin
          bus.alu_op = f7_q ? OP_SUB : OP_ADD;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = bus.alu_out;
        end
        // Differing signs decide the compare directly; otherwise the SUB sign is exact.
        3'b010: begin
          bus.alu_op = OP_SUB;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = {{(XLEN-1){1'b0}},
                        (opa_q[XLEN-1] ^ opb_q[XLEN-1]) ? opa_q[XLEN-1] : bus.alu_sign};
        end
        3'b011: begin
          bus.alu_op = OP_SUB;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = {{(XLEN-1){1'b0}},
                        (opa_q[XLEN-1] ^ opb_q[XLEN-1]) ? opb_q[XLEN-1] : bus.alu_sign};
        end
        3'b100: begin
          bus.alu_op = OP_XOR;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = bus.alu_out;
        end
        3'b110: begin
          bus.alu_op = OP_OR;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = bus.alu_out;
        end
        3'b111: begin
          bus.alu_op = OP_AND;
          bus.alu_a  = opa_q;
          bus.alu_b  = opb_q;
          exec_res   = bus.alu_out;
        end
`ifdef ALU_SEQ_FAST_SHIFT_EN
        3'b001:  exec_res = sll_res;
        3'b101:  exec_res = f7_q ? sra_res : srl_res;
`endif
        default: exec_res = '0;
      endcase
    end else if ((state_q == SHIFT) && (f3_q == 3'b001)) begin
      // Left shift by one is acc + acc on the shared ALU.
      bus.alu_op = OP_ADD;
      bus.alu_a  = acc_q;
      bus.alu_b  = acc_q;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.result     = result_q;

  // One shift step; a zero count leaves the accumulator untouched.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - SHW'(1);
      acc_d = (f3_q == 3'b001) ? bus.alu_out : {fill, acc_q[XLEN-1:1]};
    end
  end

  // Operand capture and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= '0;
      f7_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            f3_q  <= bus.funct3;
            f7_q  <= bus.funct7_5;
            opa_q <= bus.opa;
            opb_q <= bus.opb;
            cnt_q <= bus.opb[SHW-1:0];
            acc_q <= bus.opa;
          end
        end
        EXEC: result_q <= exec_res;
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (last_shift) result_q <= acc_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vectors plus randomized traffic against
// a cycle-level reference of the request/response contract.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;

  alu_sequencer_if #(.XLEN(32)) bus ();

  alu_sequencer #(.XLEN(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in
  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end
  assign bus.alu_sign = bus.alu_out[31];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f7,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0:    return f7 ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7 ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    return 2;
`else
    int sh;
    sh = int'(b[4:0]);
    if (f3 == 3'd1 || f3 == 3'd5) return (sh == 0) ? 2 : sh + 1;
    return 2;
`endif
  endfunction

  // Reference: cycles remaining until the response cycle; -1 means idle.
  int          m_left = -1;
  logic [31:0] m_exp  = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = -1;
      m_last = '0;
    end else if (m_left < 0) begin
      if (bus.req_valid) begin
        m_exp  = ref_alu(bus.funct3, bus.funct7_5, bus.opa, bus.opb);
        m_left = exp_lat(bus.funct3, bus.opb) - 1;
        if (m_left == 0) m_last = m_exp;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_last = m_exp;
    end
  end

  always @(negedge clk) begin
    chk("busy",       {31'b0, bus.busy},       {31'b0, m_left >= 0});
    chk("req_ready",  {31'b0, bus.req_ready},  {31'b0, m_left < 0});
    chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, m_left == 0});
    chk("result",     bus.result, m_last);
    if (m_left <= 0) begin
      chk("alu_op_idle", {29'b0, bus.alu_op}, 32'd0);
      chk("alu_a_idle",  bus.alu_a, 32'd0);
      chk("alu_b_idle",  bus.alu_b, 32'd0);
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic wait_resp(input string name, output int lat, output logic [31:0] res);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no resp_valid required=resp_valid within 100 cycles", name);
    end
    res = bus.result;
  endtask

  task automatic do_op(input vec_t v, output int lat, output logic [31:0] res);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.funct3    = v.f3;
    bus.funct7_5  = v.f7;
    bus.opa       = v.a;
    bus.opb       = v.b;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.opa       = $urandom;
    bus.opb       = $urandom;
    bus.funct3    = 3'($urandom);
    bus.funct7_5  = 1'($urandom);
    wait_resp(v.name, lat, res);
  endtask

  logic [31:0] corners[5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] res;

    bus.req_valid = 1'b0;
    bus.funct3    = '0;
    bus.funct7_5  = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_busy",       {31'b0, bus.busy},       32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_result",     bus.result,              32'd0);
    rst = 1'b0;

    vecs.push_back('{"add",       3'd0, 1'b0, 32'd5,           32'd7,           32'd12,          2});
    vecs.push_back('{"sub",       3'd0, 1'b1, 32'd5,           32'd7,           32'hFFFF_FFFE,   2});
    vecs.push_back('{"slt_neg",   3'd2, 1'b0, 32'hFFFF_FFFF,   32'd1,           32'd1,           2});
    vecs.push_back('{"sltu_big",  3'd3, 1'b0, 32'hFFFF_FFFF,   32'd1,           32'd0,           2});
    vecs.push_back('{"slt_min",   3'd2, 1'b0, 32'h8000_0000,   32'h7FFF_FFFF,   32'd1,           2});
    vecs.push_back('{"and_f7",    3'd7, 1'b1, 32'hF0F0_F0F0,   32'hFF00_FF00,   32'hF000_F000,   2});
    vecs.push_back('{"sll_0",     3'd1, 1'b0, 32'd1,           32'd0,           32'd1,           2});
`ifdef ALU_SEQ_FAST_SHIFT_EN
    vecs.push_back('{"sll_31",    3'd1, 1'b0, 32'd1,           32'd31,          32'h8000_0000,   2});
    vecs.push_back('{"sra_4",     3'd5, 1'b1, 32'h8000_0000,   32'd4,           32'hF800_0000,   2});
    vecs.push_back('{"srl_4",     3'd5, 1'b0, 32'h8000_0000,   32'd4,           32'h0800_0000,   2});
    vecs.push_back('{"sll_30",    3'd1, 1'b0, 32'd3,           32'd30,          32'hC000_0000,   2});
`else
    vecs.push_back('{"sll_31",    3'd1, 1'b0, 32'd1,           32'd31,          32'h8000_0000,   32});
    vecs.push_back('{"sra_4",     3'd5, 1'b1, 32'h8000_0000,   32'd4,           32'hF800_0000,   5});
    vecs.push_back('{"srl_4",     3'd5, 1'b0, 32'h8000_0000,   32'd4,           32'h0800_0000,   5});
    vecs.push_back('{"sll_30",    3'd1, 1'b0, 32'd3,           32'd30,          32'hC000_0000,   31});
`endif

    foreach (vecs[i]) begin
      chk({"model_", vecs[i].name}, ref_alu(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b), vecs[i].r);
      do_op(vecs[i], lat, res);
      chk({vecs[i].name, "_result"}, res, vecs[i].r);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Reset mid-operation with the request held; it must restart and complete cleanly.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.funct3    = 3'd1;
    bus.funct7_5  = 1'b0;
    bus.opa       = 32'd3;
    bus.opb       = 32'd10;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",       {31'b0, bus.busy},       32'd0);
    chk("midrst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_resp("after_rst", lat, res);
    chk("after_rst_result", res, 32'h0000_0C00);
`ifdef ALU_SEQ_FAST_SHIFT_EN
    chk("after_rst_latency", 32'(lat), 32'd2);
`else
    chk("after_rst_latency", 32'(lat), 32'd11);
`endif

    // Random traffic: requests may arrive while busy and must be ignored.
    repeat (4000) begin
      @(negedge clk);
      bus.req_valid = 1'($urandom);
      bus.funct3    = 3'($urandom);
      bus.funct7_5  = 1'($urandom);
      bus.opa       = pick();
      bus.opb       = ($urandom_range(0, 1) == 0) ? pick() : 32'($urandom_range(0, 3));
      rst           = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
